vector_lsu: RTL and testbench

Vector load/store unit for the vector accelerator. It sits between the vector decoder and the vector register file. On a start pulse it walks the active elements of one 128-bit vector register, issuing one data-memory transaction per element on an OBI-style port. Loads return an assembled 128-bit `load_data` word for the `VREG_WB_SRC_MEMORY` writeback path. Stores take their data from `vs3_data`.

---
 rtl/accelerator_pkg.sv | 32 +++
 rtl/vlsu_lane_align.sv | 40 ++++
 rtl/vector_lsu.sv | 254 +++++++++++++++++++++++++
 tb/tb_vector_lsu.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accelerator_pkg.sv
// Shared types and constants for the vector accelerator.
package accelerator_pkg;

  // Vector register width in bits.
  localparam int VLEN = 128;

  // Vector register file writeback source; the LSU load result feeds MEMORY.
  typedef enum logic [1:0] {
    VREG_WB_SRC_ALU    = 2'd0,
    VREG_WB_SRC_MEMORY = 2'd1,
    VREG_WB_SRC_SCALAR = 2'd2
  } vreg_wb_src_t;

  // Load/store unit sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } vlsu_state_t;

  // Byte-enable pattern of one element at lane offset 0; illegal SEW gives none.
  function automatic logic [3:0] sew_byte_mask(input logic [1:0] sew);
    case (sew)
      2'd0:    return 4'h1;
      2'd1:    return 4'h3;
      2'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/vlsu_lane_align.sv
// Combinational lane steering between a vector element and a 32-bit memory word.
module vlsu_lane_align #(
  parameter int VLEN  = 128,
  parameter int IDX_W = $clog2(VLEN / 8)
) (
  input  logic [1:0]       vsew,
  input  logic [1:0]       lane,
  input  logic [IDX_W-1:0] elem_idx,
  input  logic [VLEN-1:0]  store_data,
  input  logic [31:0]      data_rdata,
  output logic [3:0]       data_be,
  output logic [31:0]      data_wdata,
  output logic             misalign,
  output logic [31:0]      load_elem
);
  import accelerator_pkg::*;

  localparam int SH_W = IDX_W + 3;

  logic [31:0]     sew_mask;
  logic [SH_W-1:0] src_shamt;
  logic [VLEN-1:0] src_shifted;

  // Select the element from the source register and place it on its byte lanes.
  always_comb begin
    case (vsew)
      2'd0:    sew_mask = 32'h0000_00FF;
      2'd1:    sew_mask = 32'h0000_FFFF;
      2'd2:    sew_mask = 32'hFFFF_FFFF;
      default: sew_mask = 32'h0000_0000;
    endcase
    src_shamt   = {elem_idx, 3'b000} << vsew;
    src_shifted = store_data >> src_shamt;
    data_wdata  = (src_shifted[31:0] & sew_mask) << {lane, 3'b000};
    load_elem   = (data_rdata >> {lane, 3'b000}) & sew_mask;
    data_be     = sew_byte_mask(vsew) << lane;
    misalign    = ((vsew == 2'd1) && lane[0]) || ((vsew == 2'd2) && (lane != 2'd0));
  end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: walks the active elements of one vector register,
// one OBI-style memory transaction per element, at most one outstanding.
module vector_lsu #(
  parameter int VLEN = accelerator_pkg::VLEN
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            start,
  input  logic            store,
  input  logic [31:0]     base_addr,
  input  logic [31:0]     stride,
  input  logic [1:0]      vsew,
  input  logic [4:0]      vl,
  input  logic [VLEN-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [VLEN-1:0] load_data,
  output logic            data_req,
  input  logic            data_gnt,
  output logic [31:0]     data_addr,
  output logic            data_we,
  output logic [3:0]      data_be,
  output logic [31:0]     data_wdata,
  input  logic            data_rvalid,
  input  logic [31:0]     data_rdata,
  input  logic            data_err
);
  import accelerator_pkg::*;

  localparam int MAX_ELEMS = VLEN / 8;
  localparam int IDX_W     = $clog2(MAX_ELEMS);
  localparam int CNT_W     = IDX_W + 1;
  localparam int SH_W      = IDX_W + 3;

  vlsu_state_t     state_q, state_d;
  logic            store_q, store_d;
  logic [31:0]     stride_q, stride_d;
  logic [31:0]     addr_q, addr_d;
  logic [1:0]      vsew_q, vsew_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [VLEN-1:0] store_data_q, store_data_d;
  logic [VLEN-1:0] load_data_q, load_data_d;
  logic            error_q, error_d;
  logic            data_req_q, data_req_d;
  logic            data_we_q, data_we_d;
  logic [31:0]     data_addr_q, data_addr_d;
  logic [3:0]      data_be_q, data_be_d;
  logic [31:0]     data_wdata_q, data_wdata_d;
  logic            pend_mis_q, pend_mis_d;

  logic [31:0]      next_addr;
  logic [CNT_W-1:0] next_idx;
  logic [CNT_W-1:0] eff_n;
  logic [31:0]      vl_ext, max_ext;
  logic [SH_W-1:0]  ld_shamt;

  logic [1:0]       al_vsew;
  logic [1:0]       al_lane;
  logic [IDX_W-1:0] al_idx;
  logic [VLEN-1:0]  al_sdata;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata;
  logic             al_mis;
  logic [31:0]      al_load_elem;

  assign next_addr = addr_q + stride_q;
  assign next_idx  = idx_q + 1'b1;
  assign ld_shamt  = {idx_q[IDX_W-1:0], 3'b000} << vsew_q;

  // Effective element count: vl clipped to what fits in one register at this SEW.
  always_comb begin
    vl_ext  = 32'(vl);
    max_ext = 32'(MAX_ELEMS >> vsew);
    eff_n   = CNT_W'((vl_ext < max_ext) ? vl_ext : max_ext);
  end

  // Lane aligner input select: the response element while waiting, otherwise the
  // element about to be requested (element 0 from the live inputs in IDLE).
  always_comb begin
    case (state_q)
      IDLE: begin
        al_vsew  = vsew;
        al_lane  = base_addr[1:0];
        al_idx   = '0;
        al_sdata = store_data;
      end
      WAIT: begin
        al_vsew  = vsew_q;
        al_lane  = addr_q[1:0];
        al_idx   = idx_q[IDX_W-1:0];
        al_sdata = store_data_q;
      end
      default: begin
        al_vsew  = vsew_q;
        al_lane  = next_addr[1:0];
        al_idx   = next_idx[IDX_W-1:0];
        al_sdata = store_data_q;
      end
    endcase
  end

  vlsu_lane_align #(
    .VLEN  (VLEN),
    .IDX_W (IDX_W)
  ) u_lane_align (
    .vsew       (al_vsew),
    .lane       (al_lane),
    .elem_idx   (al_idx),
    .store_data (al_sdata),
    .data_rdata (data_rdata),
    .data_be    (al_be),
    .data_wdata (al_wdata),
    .misalign   (al_mis),
    .load_elem  (al_load_elem)
  );

  // Next-state logic. The request registers for element i+1 are loaded at the
  // grant of element i, so the misalign verdict is ready before REQ is entered;
  // a REQ cycle with data_req low therefore means a misaligned element.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    stride_d     = stride_q;
    addr_d       = addr_q;
    vsew_d       = vsew_q;
    n_d          = n_q;
    idx_d        = idx_q;
    store_data_d = store_data_q;
    load_data_d  = load_data_q;
    error_d      = error_q;
    data_req_d   = data_req_q;
    data_we_d    = data_we_q;
    data_addr_d  = data_addr_q;
    data_be_d    = data_be_q;
    data_wdata_d = data_wdata_q;
    pend_mis_d   = pend_mis_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          store_d      = store;
          stride_d     = stride;
          vsew_d       = vsew;
          n_d          = eff_n;
          idx_d        = '0;
          addr_d       = base_addr;
          store_data_d = store_data;
          load_data_d  = '0;
          error_d      = 1'b0;
          data_we_d    = store;
          if (vsew == 2'd3) begin
            state_d = DONE;
            error_d = 1'b1;
          end else if (eff_n == '0) begin
            state_d = DONE;
          end else begin
            state_d      = REQ;
            data_req_d   = !al_mis;
            data_addr_d  = {base_addr[31:2], 2'b00};
            data_be_d    = al_be;
            data_wdata_d = al_wdata;
          end
        end
      end
      REQ: begin
        if (!data_req_q) begin
          state_d = DONE;
          error_d = 1'b1;
        end else if (data_gnt) begin
          state_d      = WAIT;
          data_req_d   = 1'b0;
          data_addr_d  = {next_addr[31:2], 2'b00};
          data_be_d    = al_be;
          data_wdata_d = al_wdata;
          pend_mis_d   = al_mis;
        end
      end
      WAIT: begin
        if (data_rvalid) begin
          if (data_err) begin
            state_d = DONE;
            error_d = 1'b1;
          end else begin
            if (!store_q) begin
              load_data_d = load_data_q | (VLEN'(al_load_elem) << ld_shamt);
            end
            if (next_idx == n_q) begin
              state_d = DONE;
            end else begin
              state_d    = REQ;
              idx_d      = next_idx;
              addr_d     = next_addr;
              data_req_d = !pend_mis_q;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      stride_q     <= '0;
      addr_q       <= '0;
      vsew_q       <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      store_data_q <= '0;
      load_data_q  <= '0;
      error_q      <= 1'b0;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_addr_q  <= '0;
      data_be_q    <= '0;
      data_wdata_q <= '0;
      pend_mis_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      stride_q     <= stride_d;
      addr_q       <= addr_d;
      vsew_q       <= vsew_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      store_data_q <= store_data_d;
      load_data_q  <= load_data_d;
      error_q      <= error_d;
      data_req_q   <= data_req_d;
      data_we_q    <= data_we_d;
      data_addr_q  <= data_addr_d;
      data_be_q    <= data_be_d;
      data_wdata_q <= data_wdata_d;
      pend_mis_q   <= pend_mis_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign error      = done & error_q;
  assign load_data  = load_data_q;
  assign data_req   = data_req_q;
  assign data_we    = data_we_q;
  assign data_addr  = data_addr_q;
  assign data_be    = data_be_q;
  assign data_wdata = data_wdata_q;

endmodule

// File: tb/tb_vector_lsu.sv
// Directed self-checking bench for vector_lsu with a small memory responder.
module tb_vector_lsu;
  localparam int VLEN = 128;

  logic            clk = 1'b0;
  logic            n_reset = 1'b0;
  logic            start = 1'b0;
  logic            store = 1'b0;
  logic [31:0]     base_addr = '0;
  logic [31:0]     stride = '0;
  logic [1:0]      vsew = '0;
  logic [4:0]      vl = '0;
  logic [VLEN-1:0] store_data = '0;
  logic            busy, done, error;
  logic [VLEN-1:0] load_data;
  logic            data_req, data_we;
  logic [31:0]     data_addr, data_wdata;
  logic [3:0]      data_be;
  logic            data_gnt = 1'b0;
  logic            data_rvalid = 1'b0;
  logic [31:0]     data_rdata = '0;
  logic            data_err = 1'b0;

  vector_lsu #(.VLEN(VLEN)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .start       (start),
    .store       (store),
    .base_addr   (base_addr),
    .stride      (stride),
    .vsew        (vsew),
    .vl          (vl),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .load_data   (load_data),
    .data_req    (data_req),
    .data_gnt    (data_gnt),
    .data_addr   (data_addr),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_wdata  (data_wdata),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .data_err    (data_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Memory and transaction log (owned by the responder; the stimulus only reads).
  logic [31:0] mem [0:1023];
  logic [31:0] log_addr [0:127];
  logic [3:0]  log_be [0:127];
  logic [31:0] log_wdata [0:127];
  logic        log_we [0:127];
  int          log_reqcyc [0:127];
  int          log_cyc [0:127];
  int          txn_cnt = 0, total_req = 0, unstable = 0, done_cnt = 0;
  int          req_run = 0, pend_cnt = 0, pend_txn = 0;
  logic [31:0] pend_rdata = '0;
  logic [68:0] snap = '0;
  int          done_cyc = 0;
  logic        done_err = 1'b0;
  logic [VLEN-1:0] done_ld = '0;

  // Knobs written only by the stimulus.
  int t0 = 0, stall_txn = -1, stall_len = 0, rsp_delay = 0, err_txn = -1;
  int txn_base = 0, req_base = 0, done_base = 0, unst_base = 0;

  // Memory responder and done monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    data_rvalid = 1'b0;
    data_err    = 1'b0;
    data_rdata  = '0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        data_rvalid = 1'b1;
        data_rdata  = pend_rdata;
        data_err    = (pend_txn == err_txn);
      end
    end
    data_gnt = 1'b0;
    if (data_req) begin
      total_req++;
      if (req_run == 0) snap = {data_addr, data_be, data_wdata, data_we};
      else if (snap !== {data_addr, data_be, data_wdata, data_we}) unstable++;
      req_run++;
      if (txn_cnt != stall_txn || req_run > stall_len) begin
        data_gnt = 1'b1;
        if (txn_cnt < 128) begin
          log_addr[txn_cnt]   = data_addr;
          log_be[txn_cnt]     = data_be;
          log_wdata[txn_cnt]  = data_wdata;
          log_we[txn_cnt]     = data_we;
          log_reqcyc[txn_cnt] = req_run;
          log_cyc[txn_cnt]    = cyc - t0;
        end
        pend_txn   = txn_cnt;
        pend_rdata = mem[data_addr[11:2]];
        pend_cnt   = 1 + rsp_delay;
        txn_cnt++;
        req_run = 0;
      end
    end else begin
      req_run = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc - t0;
      done_err = error;
      done_ld  = load_data;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic st, input logic [31:0] ba, input logic [31:0] sd,
                          input logic [1:0] sew, input logic [4:0] n, input logic [VLEN-1:0] sdat);
    @(negedge clk);
    store = st; base_addr = ba; stride = sd; vsew = sew; vl = n; store_data = sdat;
    start = 1'b1;
    t0 = cyc; txn_base = txn_cnt; req_base = total_req; done_base = done_cnt; unst_base = unstable;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == done_base && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    assert (done_cnt != done_base) else begin
      errors++;
      $error("FAIL %s_timeout: observed no done expected done within 400 cycles", tag);
    end
    @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - done_base, 1);
  endtask

  initial begin
    for (int w = 0; w < 1024; w++) mem[w] = 32'hA5A5_0000 | w;
    mem[32'h40] = 32'h1111_1111;
    mem[32'h41] = 32'h2222_2222;
    mem[32'h42] = 32'h3333_3333;
    mem[32'h43] = 32'h4444_4444;
    for (int k = 0; k < 4; k++)
      mem[256 + k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, error, data_req, data_we}, 5'b0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_be_wdata", {data_be, data_wdata}, 36'h0);
    chk("rst_load_data", load_data, 128'h0);
    n_reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);

    // 32b unit-stride load, zero-wait memory
    start_op(1'b0, 32'h100, 32'd4, 2'd2, 5'd4, '0);
    wait_done("t1");
    chk("t1_txns", txn_cnt - txn_base, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_txn%0d", i), {log_addr[txn_base+i], log_be[txn_base+i], log_we[txn_base+i]},
          {32'h100 + 32'(4*i), 4'hF, 1'b0});
    chk("t1_elem3_cycle", log_cyc[txn_base+3], 7);
    chk("t1_done_cycle", done_cyc, 9);
    chk("t1_error", done_err, 1'b0);
    chk("t1_load_data", done_ld, 128'h44444444_33333333_22222222_11111111);

    // 8b store with unaligned base
    start_op(1'b1, 32'h203, 32'd1, 2'd0, 5'd3, 128'hCCBBAA);
    wait_done("t2");
    chk("t2_txns", txn_cnt - txn_base, 3);
    chk("t2_txn0", {log_addr[txn_base], log_be[txn_base], log_wdata[txn_base], log_we[txn_base]},
        {32'h200, 4'h8, 32'hAA00_0000, 1'b1});
    chk("t2_txn1", {log_addr[txn_base+1], log_be[txn_base+1], log_wdata[txn_base+1], log_we[txn_base+1]},
        {32'h204, 4'h1, 32'h0000_00BB, 1'b1});
    chk("t2_txn2", {log_addr[txn_base+2], log_be[txn_base+2], log_wdata[txn_base+2], log_we[txn_base+2]},
        {32'h204, 4'h2, 32'h0000_CC00, 1'b1});
    chk("t2_done_cycle", done_cyc, 7);
    chk("t2_load_data", done_ld, 128'h0);

    // Grant stall of 3 cycles on element 1 of a 32b store
    stall_txn = txn_cnt + 1;
    stall_len = 3;
    start_op(1'b1, 32'h100, 32'd4, 2'd2, 5'd2, 128'hDEADBEEF_12345678);
    wait_done("t3");
    stall_txn = -1;
    chk("t3_txn0", {log_addr[txn_base], log_be[txn_base], log_wdata[txn_base], log_we[txn_base]},
        {32'h100, 4'hF, 32'h1234_5678, 1'b1});
    chk("t3_txn1", {log_addr[txn_base+1], log_be[txn_base+1], log_wdata[txn_base+1], log_we[txn_base+1]},
        {32'h104, 4'hF, 32'hDEAD_BEEF, 1'b1});
    chk("t3_req_cycles", log_reqcyc[txn_base+1], 4);
    chk("t3_unstable", unstable - unst_base, 0);
    chk("t3_done_cycle", done_cyc, 8);

    // Misaligned 16b access
    start_op(1'b0, 32'h301, 32'd2, 2'd1, 5'd2, '0);
    wait_done("t4");
    chk("t4_req_cycles", total_req - req_base, 0);
    chk("t4_done_cycle", done_cyc, 2);
    chk("t4_error", done_err, 1'b1);

    // Response error on element 1 of a 32b load
    err_txn = txn_cnt + 1;
    start_op(1'b0, 32'h100, 32'd4, 2'd2, 5'd4, '0);
    wait_done("t5");
    err_txn = -1;
    chk("t5_txns", txn_cnt - txn_base, 2);
    chk("t5_done_cycle", done_cyc, 5);
    chk("t5_error", done_err, 1'b1);
    chk("t5_load_data", done_ld, 128'h1111_1111);

    // vl = 0
    start_op(1'b0, 32'h100, 32'd1, 2'd0, 5'd0, '0);
    wait_done("t6");
    chk("t6_req_cycles", total_req - req_base, 0);
    chk("t6_done_cycle_err", {done_cyc[7:0], done_err}, {8'd1, 1'b0});

    // Illegal SEW
    start_op(1'b0, 32'h100, 32'd4, 2'd3, 5'd4, '0);
    wait_done("t6b");
    chk("t6b_req_cycles", total_req - req_base, 0);
    chk("t6b_done_cycle_err", {done_cyc[7:0], done_err}, {8'd1, 1'b1});

    // vl = 20 at 8b is clipped to 16 elements
    start_op(1'b0, 32'h400, 32'd1, 2'd0, 5'd20, '0);
    wait_done("t7");
    chk("t7_txns", txn_cnt - txn_base, 16);
    chk("t7_last_txn", {log_addr[txn_base+15], log_be[txn_base+15]}, {32'h40C, 4'h8});
    chk("t7_done_cycle", done_cyc, 33);
    chk("t7_load_data", done_ld, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    // 16b load with negative stride
    start_op(1'b0, 32'h106, 32'hFFFF_FFFA, 2'd1, 5'd2, '0);
    wait_done("t8");
    chk("t8_txn0", {log_addr[txn_base], log_be[txn_base]}, {32'h104, 4'hC});
    chk("t8_txn1", {log_addr[txn_base+1], log_be[txn_base+1]}, {32'h100, 4'h3});
    chk("t8_load_data", done_ld, 128'h1111_2222);

    // start while busy is ignored, not queued
    start_op(1'b0, 32'h100, 32'd4, 2'd2, 5'd4, '0);
    @(negedge clk);
    store = 1'b1; base_addr = 32'h500; start = 1'b1;
    @(negedge clk);
    start = 1'b0; store = 1'b0;
    wait_done("t9");
    repeat (5) @(negedge clk);
    chk("t9_txns", txn_cnt - txn_base, 4);
    chk("t9_last_txn", {log_addr[txn_base+3], log_we[txn_base+3]}, {32'h10C, 1'b0});
    chk("t9_done_cycle", done_cyc, 9);
    chk("t9_idle_after", busy, 1'b0);
    chk("t9_load_data", done_ld, 128'h44444444_33333333_22222222_11111111);

    // Reset asserted in WAIT; the late response arrives in IDLE
    rsp_delay = 3;
    start_op(1'b0, 32'h100, 32'd4, 2'd2, 5'd4, '0);
    @(negedge clk);
    #1 n_reset = 1'b0;
    #1;
    chk("t10_rst_ctrl", {busy, done, error, data_req, data_we}, 5'b0);
    chk("t10_rst_addr_be", {data_addr, data_be, data_wdata}, 68'h0);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (8) @(negedge clk);
    rsp_delay = 0;
    chk("t10_txns", txn_cnt - txn_base, 1);
    chk("t10_no_done", done_cnt - done_base, 0);
    chk("t10_idle", busy, 1'b0);
    chk("t10_load_data", load_data, 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
